// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of a word-only data memory.
// Sub-word loads extract and extend a lane; sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_load,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_misaligned,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] mem_a,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } state_t;

    state_t state, state_n;

    logic [DM_ADDRESS-1:0] addr_q;
    logic [2:0]            f3_q;
    logic                  load_q;
    logic [DATA_W-1:0]     wd_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  mis_q;

    logic                  f3_ok;
    logic                  aligned;
    logic                  err;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic [DATA_W-1:0]     load_ext;
    logic [DATA_W-1:0]     merged;

    // Upper address bits wrap within the memory and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DM_ADDRESS];

    always_comb begin
        f3_ok = 1'b0;
        unique case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = req_load;
            default:                f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        aligned = 1'b1;
        unique case (1'b1)
            req_funct3[1:0] == 2'b01: aligned = !req_addr[0];
            req_funct3[1:0] == 2'b10: aligned = req_addr[1:0] == 2'b00;
            default:                  aligned = 1'b1;
        endcase
    end

    assign err = !f3_ok || !aligned;

    always_comb begin
        byte_v = mem_rd[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_v = mem_rd[7:0];
            2'd1: byte_v = mem_rd[15:8];
            2'd2: byte_v = mem_rd[23:16];
            2'd3: byte_v = mem_rd[31:24];
            default: byte_v = mem_rd[7:0];
        endcase
        half_v = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    end

    always_comb begin
        load_ext = mem_rd;
        unique case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'b0, byte_v};
            3'b101:  load_ext = {16'b0, half_v};
            default: load_ext = mem_rd;
        endcase
    end

    // Only the addressed lane is replaced; the rest of the word is kept.
    always_comb begin
        merged = mem_rd;
        if (f3_q[0]) begin
            if (addr_q[1])
                merged[31:16] = wd_q[15:0];
            else
                merged[15:0] = wd_q[15:0];
        end else begin
            unique case (addr_q[1:0])
                2'd0: merged[7:0]   = wd_q[7:0];
                2'd1: merged[15:8]  = wd_q[7:0];
                2'd2: merged[23:16] = wd_q[7:0];
                2'd3: merged[31:24] = wd_q[7:0];
                default: merged = mem_rd;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    if (err)
                        state_n = RESP;
                    else if (req_load || req_funct3 != 3'b010)
                        state_n = RD;
                    else
                        state_n = WR;
                end
            end
            RD:      state_n = CAP;
            CAP:     state_n = load_q ? RESP : WR;
            WR:      state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            load_q  <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr[DM_ADDRESS-1:0];
                        f3_q   <= req_funct3;
                        load_q <= req_load;
                        wd_q   <= req_wdata;
                        if (err) begin
                            rdata_q <= '0;
                            mis_q   <= 1'b1;
                        end
                    end
                end
                CAP: begin
                    if (load_q) begin
                        rdata_q <= load_ext;
                        mis_q   <= 1'b0;
                    end else begin
                        wd_q <= merged;
                    end
                end
                WR: begin
                    rdata_q <= '0;
                    mis_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready       = state == IDLE;
    assign resp_valid      = state == RESP;
    assign MemRead         = state == RD || state == CAP;
    assign MemWrite        = state == WR;
    assign mem_a           = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign mem_wd          = (state == WR) ? wd_q : '0;
    assign mem_funct3      = 3'b010;
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model plus response scoreboard.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        MemRead;
    logic        MemWrite;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_load(req_load),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned),
        .MemRead(MemRead),
        .MemWrite(MemWrite),
        .mem_a(mem_a),
        .mem_wd(mem_wd),
        .mem_funct3(mem_funct3),
        .mem_rd(mem_rd)
    );

    logic [31:0] mem [0:127];
    logic        pl_en = 1'b0;
    logic [6:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (MemWrite)
            mem[mem_a[8:2]] <= mem_wd;
        if (MemRead)
            mem_rd <= mem[mem_a[8:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    int cyc;
    int checks;
    int errors;
    int rd_cnt;
    int wr_cnt;
    int resp_cnt;
    int pushed;
    int acc_cyc;
    int wr_cyc;
    logic [8:0]  last_wa;
    logic [31:0] last_wd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (MemRead && MemWrite)
                check("rd_wr_excl", 32'd1, 32'd0);
            if (MemRead)
                rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                wr_cyc  = cyc;
                last_wa = mem_a;
                last_wd = mem_wd;
            end
            if (resp_valid) begin
                resp_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rdata", resp_rdata, e.rdata);
                    check("mis", {31'b0, resp_misaligned}, {31'b0, e.mis});
                    check("lat", cyc - e.acc, e.lat);
                end
            end
        end
    end

    task automatic preload(input logic [6:0] idx, input logic [31:0] d);
        @(posedge clk);
        #1;
        pl_en   = 1'b1;
        pl_idx  = idx;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic em,
                         input int lat, input logic hold,
                         input logic track);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_load   = ld;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready)
            check("accept_timeout", 32'd0, 32'd1);
        acc_cyc = cyc;
        if (track) begin
            e.rdata = er;
            e.mis   = em;
            e.lat   = lat;
            e.acc   = cyc;
            sb.push_back(e);
            pushed++;
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("resp_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] er);
        issue(1'b1, f3, a, 32'h0, er, 1'b0, 3, 1'b0, 1'b1);
    endtask

    task automatic bad(input logic l, input logic [2:0] f3,
                       input logic [31:0] a);
        issue(l, f3, a, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 1'b0, 1'b1);
    endtask

    int t0;
    int a1;
    int a2;
    int r0;
    int w0;
    int c0;

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_load   = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;
        preload(7'd0, 32'h0123_4567);
        preload(7'd4, 32'h8899_AABB);
        preload(7'd16, 32'h1122_3344);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_memread", {31'b0, MemRead}, 32'd0);
        check("rst_memwrite", {31'b0, MemWrite}, 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_mis", {31'b0, resp_misaligned}, 32'd0);
        check("rst_wd", mem_wd, 32'h0);
        check("mem_funct3", {29'b0, mem_funct3}, 32'd2);

        ld(3'b000, 32'h13, 32'hFFFF_FF88);
        ld(3'b100, 32'h13, 32'h0000_0088);
        ld(3'b001, 32'h12, 32'hFFFF_8899);
        ld(3'b101, 32'h10, 32'h0000_AABB);
        ld(3'b000, 32'h11, 32'hFFFF_FFAA);
        ld(3'b100, 32'h12, 32'h0000_0099);
        ld(3'b010, 32'h10, 32'h8899_AABB);
        ld(3'b010, 32'h210, 32'h8899_AABB);
        drain();

        issue(1'b0, 3'b000, 32'h41, 32'h0000_00AB, 32'h0, 1'b0, 4,
              1'b0, 1'b1);
        t0 = acc_cyc;
        drain();
        check("sb_wd", last_wd, 32'h1122_AB44);
        check("sb_wa", {23'b0, last_wa}, 32'h40);
        check("sb_wr_t", wr_cyc - t0, 32'd3);
        issue(1'b0, 3'b001, 32'h42, 32'h5555_CAFE, 32'h0, 1'b0, 4,
              1'b0, 1'b1);
        drain();
        check("sh_wd", last_wd, 32'hCAFE_AB44);
        check("sh_mem", mem[16], 32'hCAFE_AB44);

        w0 = wr_cnt;
        issue(1'b0, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 2,
              1'b0, 1'b1);
        t0 = acc_cyc;
        drain();
        check("sw_wr_cnt", wr_cnt - w0, 32'd1);
        check("sw_wr_t", wr_cyc - t0, 32'd1);
        check("sw_wa", {23'b0, last_wa}, 32'h20);
        check("sw_wd", last_wd, 32'hDEAD_BEEF);
        ld(3'b010, 32'h20, 32'hDEAD_BEEF);
        drain();
        repeat (3) @(negedge clk);
        check("rdata_hold", resp_rdata, 32'hDEAD_BEEF);

        r0 = rd_cnt;
        w0 = wr_cnt;
        bad(1'b1, 3'b010, 32'h06);
        bad(1'b0, 3'b001, 32'h05);
        bad(1'b1, 3'b011, 32'h00);
        bad(1'b0, 3'b100, 32'h00);
        bad(1'b1, 3'b101, 32'h11);
        drain();
        check("err_no_read", rd_cnt - r0, 32'd0);
        check("err_no_write", wr_cnt - w0, 32'd0);

        c0 = resp_cnt;
        issue(1'b1, 3'b010, 32'h00, 32'h0, 32'h0123_4567, 1'b0, 3,
              1'b1, 1'b1);
        a1 = acc_cyc;
        issue(1'b0, 3'b010, 32'h04, 32'h0BAD_F00D, 32'h0, 1'b0, 2,
              1'b0, 1'b1);
        a2 = acc_cyc;
        drain();
        check("b2b_gap", a2 - a1, 32'd4);
        check("b2b_resp_cnt", resp_cnt - c0, 32'd2);
        check("b2b_mem", mem[1], 32'h0BAD_F00D);

        w0 = wr_cnt;
        c0 = resp_cnt;
        issue(1'b0, 3'b000, 32'h40, 32'h0000_0055, 32'h0, 1'b0, 4,
              1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("abort_in_cap", {31'b0, MemRead}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_memwrite", {31'b0, MemWrite}, 32'd0);
        check("abort_resp", {31'b0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'h0);
        repeat (6) @(negedge clk);
        check("abort_wr_cnt", wr_cnt - w0, 32'd0);
        check("abort_resp_cnt", resp_cnt - c0, 32'd0);
        check("abort_mem", mem[16], 32'hCAFE_AB44);
        check("resp_total", resp_cnt, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts load/store requests from the datapath through a valid/ready handshake.
- Drives word-only MemRead/MemWrite/address/write-data to the data memory.
- Performs byte/halfword lane extraction, sign/zero extension, and read-modify-write for sub-word stores.
- Flags misaligned or illegal-funct3 requests without touching memory.

Parameters:
- DM_ADDRESS, 9, width of the memory byte address driven to the data memory.
- DATA_W, 32, data width; the block is defined for 32 only.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept a request.
- req_load  input  1  1 = load, 0 = store.
- req_funct3  input  3  RISC-V funct3 (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010).
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  DATA_W  store data (rs2).
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  DATA_W  extended load result; 0 for stores and errors.
- resp_misaligned  output  1  request rejected (misaligned or illegal funct3); valid with resp_valid.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable, full-word write.
- mem_a  output  DM_ADDRESS  word-aligned byte address: req_addr[DM_ADDRESS-1:2] followed by 2'b00.
- mem_wd  output  DATA_W  memory write data.
- mem_funct3  output  3  constant 3'b010; memory is always accessed as a word.
- mem_rd  input  DATA_W  memory read data, valid in the cycle after MemRead first asserts.

Behaviour:
- States: IDLE, RD, CAP, WR, RESP. Reset (synchronous) forces IDLE and clears all latched request fields.
- In IDLE, and after reset: req_ready=1, resp_valid=0, MemRead=0, MemWrite=0, resp_rdata=0, resp_misaligned=0, mem_wd=0.
- req_ready=1 only in IDLE. A request is accepted in cycle T0 when req_valid&&req_ready; addr, funct3, load, and wdata are latched.
- Error check at acceptance:
  - LH/LHU/SH with addr[0]=1 is an error.
  - LW/SW with addr[1:0]!=0 is an error.
  - Load funct3 011/110/111 and store funct3 >=011 are errors.
  - An error goes IDLE->RESP. MemRead/MemWrite never assert for an error.
- LW/LB/LH/LBU/LHU: IDLE->RD->CAP->RESP.
  - MemRead=1 in RD and CAP. mem_a is held stable.
  - CAP samples mem_rd into the result register.
  - Byte lane = addr[1:0]; halfword lane = addr[1]. LB/LH sign-extend, LBU/LHU zero-extend.
  - resp_valid at T3.
- SW: IDLE->WR->RESP. MemWrite=1 in WR with mem_wd=wdata. resp_valid at T2.
- SB/SH (read-modify-write): IDLE->RD->CAP->WR->RESP.
  - CAP merges wdata[7:0] (SB) or wdata[15:0] (SH) into the addressed lane of mem_rd; the other bytes are preserved.
  - WR writes the merged word. resp_valid at T4.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response back-pressure. A new request may be accepted in the cycle after RESP.
- MemRead and MemWrite are never high in the same cycle. mem_a is only meaningful while MemRead or MemWrite is high and is held constant across RD/CAP/WR of one request.
- resp_rdata and resp_misaligned hold their values until the next RESP. They are cleared only by reset.
- Reset mid-operation: the transaction is aborted. No MemWrite in the cycle after reset. No resp_valid for the aborted request.
- Address bits above DM_ADDRESS-1 are ignored (wrap within the memory).

Test Plan:
1. Memory word 0x10 = 0x8899AABB; LB addr 0x13 -> resp at T3, resp_rdata=0xFFFFFF88; LBU addr 0x13 -> 0x00000088; LH addr 0x12 -> 0xFFFF8899; LHU 0x10 -> 0x0000AABB.
2. SW addr 0x20 wdata 0xDEADBEEF -> MemWrite high only at T1, mem_a=0x020, mem_wd=0xDEADBEEF, resp_valid at T2, resp_rdata=0; LW 0x20 then returns 0xDEADBEEF.
3. Word 0x40 = 0x11223344; SB addr 0x41 wdata 0x000000AB -> RD/CAP/WR, mem_wd=0x1122AB44, resp at T4; SH addr 0x42 wdata 0xCAFE -> mem_wd=0xCAFEAB44.
4. LW addr 0x06, SH addr 0x05, and load funct3=011 -> resp_valid at T1 with resp_misaligned=1, resp_rdata=0, MemRead=MemWrite=0 throughout.
5. req_valid held high with back-to-back LW 0x00, SW 0x04 -> req_ready low in RD/CAP/WR/RESP; second request accepted in the cycle after the first RESP; one resp_valid pulse per request.
6. Reset asserted in CAP of an SB -> next cycle IDLE, req_ready=1, MemWrite never asserted, no resp_valid, memory word unchanged.
